// File: rtl/d_latch_pkg.sv
// d_latch_pkg: shared width default and data word type for the synchronous latch emulation
package d_latch_pkg;
  localparam int DLATCH_DEFAULT_W = 8;
  typedef logic [DLATCH_DEFAULT_W-1:0] dlatch_word_t;
endpackage

// File: rtl/d_latch_bit.sv
// d_latch_bit: one-bit latch cell built from an async-reset flop, a mode mux and a complement output
module d_latch_bit #(
  parameter bit RESET_BIT   = 1'b0,
  parameter bit TRANSPARENT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic en,
  output logic q,
  output logic qn
);
  logic hold;
  // capture data on enabled edges, otherwise keep the last captured value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold <= RESET_BIT;
    else if (en) hold <= d;
  end
  // reset wins over the transparent path so Q is forced even with enable high
  always_comb begin
    q = !rst_n ? RESET_BIT : (TRANSPARENT && en) ? d : hold;
    qn = ~q;
  end
endmodule

// File: rtl/d_latch_n.sv
// d_latch_n: N-bit D-latch emulated with flops on a single clock, with complementary output
module d_latch_n
  import d_latch_pkg::*;
#(
  parameter int         N           = DLATCH_DEFAULT_W,
  parameter logic [N-1:0] RESET_VALUE = '0,
  parameter bit         TRANSPARENT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data,
  input  logic         enable,
  output logic [N-1:0] Q,
  output logic [N-1:0] Qn
);
  if (N < 1) begin : g_bad_width
    $error("d_latch_n: N must be >= 1");
  end
  for (genvar i = 0; i < N; i++) begin : g_bit
    d_latch_bit #(
      .RESET_BIT  (RESET_VALUE[i]),
      .TRANSPARENT(TRANSPARENT)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (data[i]),
      .en   (enable),
      .q    (Q[i]),
      .qn   (Qn[i])
    );
  end
endmodule

// File: tb/tb_d_latch_n.sv
// tb_d_latch_n: directed checks of transparent, registered, 1-bit, 32-bit and non-zero-reset builds
module tb_d_latch_n;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] d;
  logic [7:0]  q8t, qn8t, q8r, qn8r, q8v, qn8v;
  logic [0:0]  q1, qn1;
  logic [31:0] q32, qn32;
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  d_latch_n #(.N(8), .TRANSPARENT(1'b1)) u8t (
    .clk(clk), .rst_n(rst_n), .data(d[7:0]), .enable(en), .Q(q8t), .Qn(qn8t));
  d_latch_n #(.N(8), .TRANSPARENT(1'b0)) u8r (
    .clk(clk), .rst_n(rst_n), .data(d[7:0]), .enable(en), .Q(q8r), .Qn(qn8r));
  d_latch_n #(.N(8), .RESET_VALUE(8'hC3), .TRANSPARENT(1'b1)) u8v (
    .clk(clk), .rst_n(rst_n), .data(d[7:0]), .enable(en), .Q(q8v), .Qn(qn8v));
  d_latch_n #(.N(1), .TRANSPARENT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .data(d[1:1]), .enable(en), .Q(q1), .Qn(qn1));
  d_latch_n #(.N(32), .TRANSPARENT(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .data(d), .enable(en), .Q(q32), .Qn(qn32));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; d = 32'hFFFF_FFFF;
    #2;
    check("rst_t_q", 32'(q8t), 32'h00);
    check("rst_t_qn", 32'(qn8t), 32'hFF);
    check("rst_r_q", 32'(q8r), 32'h00);
    check("rst_v_q", 32'(q8v), 32'hC3);
    check("rst_v_qn", 32'(qn8v), 32'h3C);
    check("rst_1_q", 32'(q1), 32'h0);
    check("rst_1_qn", 32'(qn1), 32'h1);
    check("rst_32_q", q32, 32'h0000_0000);
    check("rst_32_qn", qn32, 32'hFFFF_FFFF);
    tick;
    check("rst_edge_t_q", 32'(q8t), 32'h00);
    check("rst_edge_r_q", 32'(q8r), 32'h00);
    check("rst_edge_v_q", 32'(q8v), 32'hC3);
    // scenario 2: transparent pass-through, then hold
    rst_n = 1'b1; d = 32'h1234_56AA;
    #1;
    check("s2_t_q", 32'(q8t), 32'hAA);
    check("s2_t_qn", 32'(qn8t), 32'h55);
    check("s2_r_q_pre", 32'(q8r), 32'h00);
    check("s2_1_q", 32'(q1), 32'h1);
    check("s2_1_qn", 32'(qn1), 32'h0);
    check("s2_32_q", q32, 32'h1234_56AA);
    check("s2_32_qn", qn32, 32'hEDCB_A955);
    tick;
    check("s2_r_q_cap", 32'(q8r), 32'hAA);
    check("s2_r_qn_cap", 32'(qn8r), 32'h55);
    en = 1'b0; d = 32'h0000_0000;
    #1;
    check("s2_t_hold", 32'(q8t), 32'hAA);
    check("s2_1_hold", 32'(q1), 32'h1);
    check("s2_32_hold", q32, 32'h1234_56AA);
    tick;
    check("s2_t_hold_edge", 32'(q8t), 32'hAA);
    check("s2_r_hold_edge", 32'(q8r), 32'hAA);
    check("s2_32_hold_edge", q32, 32'h1234_56AA);
    check("s2_1_hold_edge", 32'(q1), 32'h1);
    // scenario 3: 55 captured and held, then F0 captured and held
    en = 1'b1; d = 32'h55;
    #1;
    check("s3_t_55", 32'(q8t), 32'h55);
    check("s3_r_prev", 32'(q8r), 32'hAA);
    tick;
    check("s3_r_55", 32'(q8r), 32'h55);
    en = 1'b0; d = 32'h33;
    #1;
    check("s3_t_55_hold", 32'(q8t), 32'h55);
    tick;
    check("s3_t_55_hold_edge", 32'(q8t), 32'h55);
    check("s3_r_55_hold_edge", 32'(q8r), 32'h55);
    en = 1'b1; d = 32'hF0;
    #1;
    check("s3_t_f0", 32'(q8t), 32'hF0);
    tick;
    en = 1'b0; d = 32'h0F;
    #1;
    check("s3_t_f0_hold", 32'(q8t), 32'hF0);
    check("s3_t_qn_0f", 32'(qn8t), 32'h0F);
    check("s3_r_f0", 32'(q8r), 32'hF0);
    check("s3_r_qn_0f", 32'(qn8r), 32'h0F);
    tick;
    check("s3_t_f0_edge", 32'(q8t), 32'hF0);
    check("s3_r_f0_edge", 32'(q8r), 32'hF0);
    // scenario 5: async reset between edges while holding F0
    rst_n = 1'b0;
    #1;
    check("s5_t_q", 32'(q8t), 32'h00);
    check("s5_t_qn", 32'(qn8t), 32'hFF);
    check("s5_r_q", 32'(q8r), 32'h00);
    check("s5_v_q", 32'(q8v), 32'hC3);
    check("s5_32_q", q32, 32'h0000_0000);
    d = 32'hFFFF_FFFF;
    tick;
    rst_n = 1'b1;
    #1;
    check("s5_rel_t_q", 32'(q8t), 32'h00);
    tick;
    check("s5_rel_t_edge", 32'(q8t), 32'h00);
    check("s5_rel_r_edge", 32'(q8r), 32'h00);
    check("s5_rel_v_edge", 32'(q8v), 32'hC3);
    // reset asserted while transparent overrides enable
    en = 1'b1; d = 32'h77;
    #1;
    check("ovr_t_pass", 32'(q8t), 32'h77);
    rst_n = 1'b0;
    #1;
    check("ovr_t_q", 32'(q8t), 32'h00);
    check("ovr_t_qn", 32'(qn8t), 32'hFF);
    check("ovr_v_q", 32'(q8v), 32'hC3);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
